// File: rtl/l2_read_word.sv
// Two-stage valid/ready sub-word extractor: selects a byte/half/word/dword from a cache line.
// Build option L2_READ_WORD_REPLICATE_EN replicates read data across all byte lanes.
module l2_read_word #(
  parameter int BITS_PER_WORD  = 64,
  parameter int WORDS_PER_LINE = 4,
  parameter int WORD_BITS      = 2,
  parameter int BYTE_BITS      = 3,
  parameter int ERR_CNT_W      = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    req_valid,
  output logic                                    req_ready,
  input  logic [BITS_PER_WORD*WORDS_PER_LINE-1:0] req_line,
  input  logic [WORD_BITS-1:0]                    req_w_off,
  input  logic [BYTE_BITS-1:0]                    req_b_off,
  input  logic [2:0]                              req_hsize,
  output logic                                    rsp_valid,
  input  logic                                    rsp_ready,
  output logic [BITS_PER_WORD-1:0]                rsp_word,
  output logic                                    rsp_err,
  output logic [ERR_CNT_W-1:0]                    err_count
);

  localparam int NBYTES = BITS_PER_WORD / 8;

  function automatic logic calc_err(input logic [BYTE_BITS-1:0] b_off,
                                    input logic [2:0]           hsize);
    int off;
    int nb;
    off = int'(b_off);
    nb  = 1 << hsize;
    if (hsize > 3'd3) return 1'b1;
    if (hsize == 3'd3 && BITS_PER_WORD == 32) return 1'b1;
    if ((off % nb) != 0) return 1'b1;
    return (off + nb > NBYTES);
  endfunction

  // Only called for legal accesses, so nb always fits inside the word.
  function automatic logic [BITS_PER_WORD-1:0] extract(input logic [BITS_PER_WORD-1:0] word,
                                                       input logic [BYTE_BITS-1:0]     b_off,
                                                       input logic [2:0]               hsize);
    logic [BITS_PER_WORD-1:0] res;
    int off;
    int nb;
    res = '0;
    off = int'(b_off);
    nb  = 1 << hsize;
    for (int k = 0; k < NBYTES; k++) begin
`ifdef L2_READ_WORD_REPLICATE_EN
      for (int j = 0; j < NBYTES; j++) begin
        if (j == off + (k % nb)) res[8*k +: 8] = word[8*j +: 8];
      end
`else
      if (k >= off && k < off + nb) res[8*k +: 8] = word[8*k +: 8];
`endif
    end
    return res;
  endfunction

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic                     r_vld_p1;
  logic [BITS_PER_WORD-1:0] r_word_p1;
  logic [BYTE_BITS-1:0]     r_boff_p1;
  logic [2:0]               r_hsize_p1;
  logic                     r_err_p1;
  logic                     r_vld_p2;
  logic [BITS_PER_WORD-1:0] r_word_p2;
  logic                     r_err_p2;
  logic [ERR_CNT_W-1:0]     r_err_cnt;

  logic                     w_s2_adv;
  logic                     w_s1_adv;
  logic                     w_accept;
  logic [BITS_PER_WORD-1:0] w_word_sel;

  assign w_s2_adv = !r_vld_p2 || rsp_ready;
  assign w_s1_adv = !r_vld_p1 || w_s2_adv;
  assign w_accept = req_valid && w_s1_adv;

  always_comb begin
    w_word_sel = '0;
    for (int i = 0; i < WORDS_PER_LINE; i++) begin
      if (req_w_off == WORD_BITS'(i)) w_word_sel = req_line[i*BITS_PER_WORD +: BITS_PER_WORD];
    end
  end

  // Stage 1: word select and access legality
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_vld_p1 <= 1'b0;
    end else if (w_s1_adv) begin
      r_vld_p1 <= req_valid;
    end
    if (w_accept) begin
      r_word_p1  <= w_word_sel;
      r_boff_p1  <= req_b_off;
      r_hsize_p1 <= req_hsize;
      r_err_p1   <= calc_err(req_b_off, req_hsize);
    end
  end

  // Stage 2: lane extraction, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_vld_p2  <= 1'b0;
      r_word_p2 <= '0;
      r_err_p2  <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      if (w_s2_adv) begin
        r_vld_p2 <= r_vld_p1;
        if (r_vld_p1) begin
          r_word_p2 <= r_err_p1 ? '0 : extract(r_word_p1, r_boff_p1, r_hsize_p1);
          r_err_p2  <= r_err_p1;
        end
      end
      if (r_vld_p2 && rsp_ready && r_err_p2) r_err_cnt <= sat_inc(r_err_cnt);
    end
  end

  assign req_ready = w_s1_adv;
  assign rsp_valid = r_vld_p2;
  assign rsp_word  = r_word_p2;
  assign rsp_err   = r_err_p2;
  assign err_count = r_err_cnt;

endmodule

// File: tb/tb_l2_read_word.sv
// Directed bench for l2_read_word: aligned reads, error cases, backpressure and mid-flight reset.
module tb_l2_read_word;

  logic         clk;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [255:0] req_line;
  logic [1:0]   req_w_off;
  logic [2:0]   req_b_off;
  logic [2:0]   req_hsize;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [63:0]  rsp_word;
  logic         rsp_err;
  logic [15:0]  err_count;

  int n_pass  = 0;
  int n_total = 0;

`ifdef L2_READ_WORD_REPLICATE_EN
  localparam logic [63:0] EXP_BYTE = 64'h0B0B0B0B0B0B0B0B;
  localparam logic [63:0] EXP_HALF = 64'h1514151415141514;
  localparam logic [63:0] EXP_W32  = 64'h0706050407060504;
`else
  localparam logic [63:0] EXP_BYTE = 64'h000000000B000000;
  localparam logic [63:0] EXP_HALF = 64'h0000151400000000;
  localparam logic [63:0] EXP_W32  = 64'h0706050400000000;
`endif
  localparam logic [63:0] EXP_DW   = 64'h1F1E1D1C1B1A1918;

  l2_read_word dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_line(req_line),
    .req_w_off(req_w_off), .req_b_off(req_b_off), .req_hsize(req_hsize),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_word(rsp_word),
    .rsp_err(rsp_err), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic drive_req(input logic [1:0] w, input logic [2:0] b, input logic [2:0] h);
    req_valid = 1'b1;
    req_w_off = w;
    req_b_off = b;
    req_hsize = h;
  endtask

  task automatic test_reset;
    rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); else n_pass++;
    n_total++; if (rsp_word !== 64'h0) $display("FAIL reset_rsp_word got %h want 0", rsp_word); else n_pass++;
    n_total++; if (rsp_err !== 1'b0) $display("FAIL reset_rsp_err got %b want 0", rsp_err); else n_pass++;
    n_total++; if (err_count !== 16'd0) $display("FAIL reset_err_count got %0d want 0", err_count); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_total++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %b want 1", req_ready); else n_pass++;
  endtask

  task automatic test_read(input string name, input logic [1:0] w, input logic [2:0] b,
                           input logic [2:0] h, input logic [63:0] exp_word, input logic exp_err);
    drive_req(w, b, h);
    @(negedge clk);
    req_valid = 1'b0;
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL %s_early_valid got %b want 0", name, rsp_valid); else n_pass++;
    @(negedge clk);
    n_total++; if (rsp_valid !== 1'b1) $display("FAIL %s_valid got %b want 1", name, rsp_valid); else n_pass++;
    n_total++; if (rsp_word !== exp_word) $display("FAIL %s_word got %h want %h", name, rsp_word, exp_word); else n_pass++;
    n_total++; if (rsp_err !== exp_err) $display("FAIL %s_err got %b want %b", name, rsp_err, exp_err); else n_pass++;
    @(negedge clk);
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL %s_drained got %b want 0", name, rsp_valid); else n_pass++;
  endtask

  task automatic test_aligned;
    test_read("byte",  2'd1, 3'd3, 3'd0, EXP_BYTE, 1'b0);
    test_read("half",  2'd2, 3'd4, 3'd1, EXP_HALF, 1'b0);
    test_read("word32", 2'd0, 3'd4, 3'd2, EXP_W32, 1'b0);
    test_read("dword", 2'd3, 3'd0, 3'd3, EXP_DW,   1'b0);
  endtask

  task automatic test_errors;
    n_total++; if (err_count !== 16'd0) $display("FAIL errcnt_start got %0d want 0", err_count); else n_pass++;
    test_read("mis_half", 2'd0, 3'd3, 3'd1, 64'h0, 1'b1);
    n_total++; if (err_count !== 16'd1) $display("FAIL errcnt_1 got %0d want 1", err_count); else n_pass++;
    test_read("hsize5", 2'd1, 3'd0, 3'd5, 64'h0, 1'b1);
    n_total++; if (err_count !== 16'd2) $display("FAIL errcnt_2 got %0d want 2", err_count); else n_pass++;
    test_read("mis_dword", 2'd3, 3'd4, 3'd3, 64'h0, 1'b1);
    n_total++; if (err_count !== 16'd3) $display("FAIL errcnt_3 got %0d want 3", err_count); else n_pass++;
  endtask

  task automatic test_back_to_back;
    rsp_ready = 1'b0;
    drive_req(2'd3, 3'd0, 3'd3);
    @(negedge clk);
    drive_req(2'd1, 3'd3, 3'd0);
    n_total++; if (req_ready !== 1'b1) $display("FAIL bp_ready_b got %b want 1", req_ready); else n_pass++;
    @(negedge clk);
    drive_req(2'd2, 3'd4, 3'd1);
    n_total++; if (req_ready !== 1'b0) $display("FAIL bp_full got %b want 0", req_ready); else n_pass++;
    n_total++; if (rsp_valid !== 1'b1 || rsp_word !== EXP_DW)
      $display("FAIL bp_hold0 got v=%b %h want v=1 %h", rsp_valid, rsp_word, EXP_DW); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_total++; if (req_ready !== 1'b0) $display("FAIL bp_full_%0d got %b want 0", i, req_ready); else n_pass++;
      n_total++; if (rsp_valid !== 1'b1 || rsp_word !== EXP_DW)
        $display("FAIL bp_hold_%0d got v=%b %h want v=1 %h", i, rsp_valid, rsp_word, EXP_DW); else n_pass++;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n_total++; if (rsp_valid !== 1'b1 || rsp_word !== EXP_BYTE)
      $display("FAIL bp_second got v=%b %h want v=1 %h", rsp_valid, rsp_word, EXP_BYTE); else n_pass++;
    @(negedge clk);
    n_total++; if (rsp_valid !== 1'b1 || rsp_word !== EXP_HALF)
      $display("FAIL bp_third got v=%b %h want v=1 %h", rsp_valid, rsp_word, EXP_HALF); else n_pass++;
    @(negedge clk);
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL bp_empty got %b want 0", rsp_valid); else n_pass++;
  endtask

  task automatic test_reset_midflight;
    logic stale;
    rsp_ready = 1'b0;
    drive_req(2'd3, 3'd0, 3'd3);
    @(negedge clk);
    drive_req(2'd1, 3'd3, 3'd0);
    @(negedge clk);
    req_valid = 1'b0;
    n_total++; if (rsp_valid !== 1'b1 || req_ready !== 1'b0)
      $display("FAIL mid_full got v=%b rdy=%b want v=1 rdy=0", rsp_valid, req_ready); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    rsp_ready = 1'b1;
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL mid_rsp_valid got %b want 0", rsp_valid); else n_pass++;
    n_total++; if (err_count !== 16'd0) $display("FAIL mid_err_count got %0d want 0", err_count); else n_pass++;
    n_total++; if (req_ready !== 1'b1) $display("FAIL mid_req_ready got %b want 1", req_ready); else n_pass++;
    stale = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) stale = 1'b1;
    end
    n_total++; if (stale !== 1'b0) $display("FAIL mid_stale got %b want 0", stale); else n_pass++;
  endtask

  initial begin
    req_line  = {64'h1F1E1D1C1B1A1918, 64'h1716151413121110,
                 64'h0F0E0D0C0B0A0908, 64'h0706050403020100};
    req_valid = 1'b0;
    req_w_off = '0;
    req_b_off = '0;
    req_hsize = '0;
    rsp_ready = 1'b1;
    rst       = 1'b0;
    test_reset();
    test_aligned();
    test_errors();
    test_back_to_back();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
